// File: rtl/flow_pkg.sv
// Shared definitions for the flow delta processor: FSM state encoding,
// default parameter values and the channel-tag width helper.
package flow_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } flow_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_LEN_WIDTH  = 16;
  localparam int DEF_CNT_WIDTH  = 32;
  localparam int DEF_XOR_EN     = 1;

  // A single channel still needs a one-bit tag.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/flow_out_stage.sv
// Single registered valid/ready output stage; accepts a new word whenever it
// is empty or being drained in the same cycle, so continuous flow has no bubble.
module flow_out_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data
);

  logic             vld_r;
  logic [WIDTH-1:0] data_r;

  assign in_rdy   = ~vld_r | out_rdy;
  assign out_vld  = vld_r;
  assign out_data = data_r;

  // Payload only changes when a new word is pushed, so it holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r  <= 1'b0;
      data_r <= {WIDTH{1'b0}};
    end else if (in_rdy) begin
      vld_r <= in_vld;
      if (in_vld) begin
        data_r <= in_data;
      end
    end
  end

endmodule

// File: rtl/flow_delta_proc.sv
// Packet delta processor: frames beats into packets, XOR-deltas middle beats,
// reports completed packets and keeps saturating per-channel packet counters.
module flow_delta_proc
  import flow_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NUM_CH     = DEF_NUM_CH,
  parameter  int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter  int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter  int XOR_EN     = DEF_XOR_EN,
  localparam int CH_WIDTH   = ch_width(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [CH_WIDTH-1:0]   in_ch,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [CH_WIDTH-1:0]   out_ch,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  fb_vld,
  output logic [CH_WIDTH-1:0]   fb_ch,
  output logic [LEN_WIDTH-1:0]  fb_len,
  output logic                  fb_err,
  input  logic [CH_WIDTH-1:0]   cnt_sel,
  output logic [CNT_WIDTH-1:0]  cnt_rdata,
  input  logic                  cnt_clr
);

  localparam int                   PW      = 2 + CH_WIDTH + DATA_WIDTH;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1'b1);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = {LEN_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  flow_state_e           state_r, state_s;
  logic                  stage_rdy_s, acc_s, push_s, start_s;
  logic                  fb_fire_s, fb_err_s;
  logic [CH_WIDTH-1:0]   fb_ch_s, beat_ch_s, ch_r;
  logic [LEN_WIDTH-1:0]  fb_len_s, len_r, len_inc_s;
  logic [DATA_WIDTH-1:0] beat_data_s, prev_r;
  logic [PW-1:0]         stage_out_s;
  logic                  fb_vld_r, fb_err_r;
  logic [CH_WIDTH-1:0]   fb_ch_r;
  logic [LEN_WIDTH-1:0]  fb_len_r;
  logic [CNT_WIDTH-1:0]  cnt_r [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_rdata_s;

  assign acc_s     = in_vld & stage_rdy_s;
  assign len_inc_s = (len_r == LEN_MAX) ? len_r : len_r + LEN_ONE;

  // State register; an asynchronous reset drops any packet in flight silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Framing decisions for the accepted beat. A sop&eop beat that also closes an
  // unterminated packet reports only the error close (one feedback slot per cycle).
  always_comb begin
    state_s     = state_r;
    push_s      = 1'b0;
    start_s     = 1'b0;
    fb_fire_s   = 1'b0;
    fb_err_s    = 1'b0;
    fb_ch_s     = ch_r;
    fb_len_s    = len_inc_s;
    beat_ch_s   = ch_r;
    beat_data_s = in_data;
    if (acc_s) begin
      case (state_r)
        IDLE: begin
          if (in_sop) begin
            push_s    = 1'b1;
            start_s   = 1'b1;
            beat_ch_s = in_ch;
            if (in_eop) begin
              fb_fire_s = 1'b1;
              fb_ch_s   = in_ch;
              fb_len_s  = LEN_ONE;
              state_s   = IDLE;
            end else begin
              state_s = PKT;
            end
          end else begin
            state_s = IDLE;
          end
        end
        PKT: begin
          push_s = 1'b1;
          if (in_sop) begin
            start_s   = 1'b1;
            beat_ch_s = in_ch;
            fb_fire_s = 1'b1;
            fb_err_s  = 1'b1;
            fb_len_s  = len_r;
            state_s   = in_eop ? IDLE : PKT;
          end else if (in_eop) begin
            fb_fire_s = 1'b1;
            state_s   = IDLE;
          end else begin
            beat_data_s = (XOR_EN != 0) ? (in_data ^ prev_r) : in_data;
            state_s     = PKT;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Per-packet context: channel tag, saturating beat count and previous raw beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_r   <= {CH_WIDTH{1'b0}};
      len_r  <= {LEN_WIDTH{1'b0}};
      prev_r <= {DATA_WIDTH{1'b0}};
    end else if (start_s) begin
      ch_r   <= in_ch;
      len_r  <= LEN_ONE;
      prev_r <= in_data;
    end else if (push_s) begin
      len_r  <= len_inc_s;
      prev_r <= in_data;
    end
  end

  // Feedback pulse; the descriptor holds its last value between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_vld_r <= 1'b0;
      fb_err_r <= 1'b0;
      fb_ch_r  <= {CH_WIDTH{1'b0}};
      fb_len_r <= {LEN_WIDTH{1'b0}};
    end else begin
      fb_vld_r <= fb_fire_s;
      if (fb_fire_s) begin
        fb_err_r <= fb_err_s;
        fb_ch_r  <= fb_ch_s;
        fb_len_r <= fb_len_s;
      end
    end
  end

  // Good-packet counters; a clear in the same cycle discards the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= {CNT_WIDTH{1'b0}};
      end
    end else if (cnt_clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= {CNT_WIDTH{1'b0}};
      end
    end else if (fb_vld_r && !fb_err_r) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((fb_ch_r == CH_WIDTH'(i)) && (cnt_r[i] != CNT_MAX)) begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Counter read mux; out-of-range selects read as zero.
  always_comb begin
    cnt_rdata_s = {CNT_WIDTH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_sel == CH_WIDTH'(i)) begin
        cnt_rdata_s = cnt_r[i];
      end else begin
        cnt_rdata_s = cnt_rdata_s;
      end
    end
  end

  flow_out_stage #(
    .WIDTH (PW)
  ) u_out_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (push_s),
    .in_rdy   (stage_rdy_s),
    .in_data  ({in_sop, in_eop, beat_ch_s, beat_data_s}),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (stage_out_s)
  );

  assign in_rdy    = stage_rdy_s;
  assign out_sop   = stage_out_s[PW-1];
  assign out_eop   = stage_out_s[PW-2];
  assign out_ch    = stage_out_s[DATA_WIDTH +: CH_WIDTH];
  assign out_data  = stage_out_s[DATA_WIDTH-1:0];
  assign fb_vld    = fb_vld_r;
  assign fb_ch     = fb_ch_r;
  assign fb_len    = fb_len_r;
  assign fb_err    = fb_err_r;
  assign cnt_rdata = cnt_rdata_s;

endmodule

// File: tb/tb_flow_delta_proc.sv
// Bench for flow_delta_proc: a default XOR instance and a bypass instance with
// 2-bit length/counter widths share one random stimulus and one packet model.
module tb_flow_delta_proc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_vld, in_sop, in_eop, out_rdy, cnt_clr;
  logic [1:0] in_ch, cnt_sel;
  logic [7:0] in_data;

  logic        a_in_rdy, a_out_vld, a_out_sop, a_out_eop, a_fb_vld, a_fb_err;
  logic [1:0]  a_out_ch, a_fb_ch;
  logic [7:0]  a_out_data;
  logic [15:0] a_fb_len;
  logic [31:0] a_cnt;
  logic        b_in_rdy, b_out_vld, b_out_sop, b_out_eop, b_fb_vld, b_fb_err;
  logic [1:0]  b_out_ch, b_fb_ch, b_fb_len, b_cnt;
  logic [7:0]  b_out_data;

  always #5 clk = ~clk;

  flow_delta_proc u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(a_in_rdy), .in_sop(in_sop),
    .in_eop(in_eop), .in_ch(in_ch), .in_data(in_data), .out_vld(a_out_vld),
    .out_rdy(out_rdy), .out_sop(a_out_sop), .out_eop(a_out_eop), .out_ch(a_out_ch),
    .out_data(a_out_data), .fb_vld(a_fb_vld), .fb_ch(a_fb_ch), .fb_len(a_fb_len),
    .fb_err(a_fb_err), .cnt_sel(cnt_sel), .cnt_rdata(a_cnt), .cnt_clr(cnt_clr)
  );

  flow_delta_proc #(.LEN_WIDTH(2), .CNT_WIDTH(2), .XOR_EN(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(b_in_rdy), .in_sop(in_sop),
    .in_eop(in_eop), .in_ch(in_ch), .in_data(in_data), .out_vld(b_out_vld),
    .out_rdy(out_rdy), .out_sop(b_out_sop), .out_eop(b_out_eop), .out_ch(b_out_ch),
    .out_data(b_out_data), .fb_vld(b_fb_vld), .fb_ch(b_fb_ch), .fb_len(b_fb_len),
    .fb_err(b_fb_err), .cnt_sel(cnt_sel), .cnt_rdata(b_cnt), .cnt_clr(cnt_clr)
  );

  // Packet-level model state
  bit         m_in_pkt;
  logic [1:0] m_ch;
  logic [7:0] m_prev;
  int         m_len;
  // Expected output register, feedback and counters
  bit         e_ovld, e_osop, e_oeop, e_fbv, e_fberr;
  logic [1:0] e_och, e_fbch;
  logic [7:0] e_oda, e_odb;
  int         e_fblen;
  longint     ca [4];
  int         cb [4];

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] seen_a [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_in_pkt = 0; m_ch = 2'd0; m_prev = 8'd0; m_len = 0;
    e_ovld = 0; e_osop = 0; e_oeop = 0; e_och = 2'd0; e_oda = 8'd0; e_odb = 8'd0;
    e_fbv = 0; e_fberr = 0; e_fbch = 2'd0; e_fblen = 0;
    for (int i = 0; i < 4; i++) begin ca[i] = 0; cb[i] = 0; end
  endtask

  // Advance the model across one clock edge with the currently driven inputs.
  task automatic model_clock(input bit acc);
    bit fire, ferr, fwd;
    logic [1:0] fch, bch;
    int flen;
    logic [7:0] da;
    fire = 0; ferr = 0; fwd = 0; fch = 2'd0; flen = 0; bch = m_ch; da = in_data;
    if (cnt_clr) begin
      for (int i = 0; i < 4; i++) begin ca[i] = 0; cb[i] = 0; end
    end else if (e_fbv && !e_fberr) begin
      if (ca[e_fbch] < 64'hFFFF_FFFF) ca[e_fbch]++;
      if (cb[e_fbch] < 3) cb[e_fbch]++;
    end
    if (acc) begin
      if (in_sop) begin
        if (m_in_pkt) begin
          fire = 1; ferr = 1; fch = m_ch; flen = m_len;
        end else if (in_eop) begin
          fire = 1; fch = in_ch; flen = 1;
        end
        fwd = 1; bch = in_ch;
        m_ch = in_ch; m_len = 1; m_prev = in_data; m_in_pkt = !in_eop;
      end else if (m_in_pkt) begin
        fwd = 1;
        if (!in_eop) da = in_data ^ m_prev;
        m_len++; m_prev = in_data;
        if (in_eop) begin fire = 1; fch = m_ch; flen = m_len; m_in_pkt = 0; end
      end
    end
    e_fbv = fire;
    if (fire) begin e_fberr = ferr; e_fbch = fch; e_fblen = flen; end
    if (!e_ovld || out_rdy) begin
      e_ovld = fwd;
      if (fwd) begin
        e_osop = in_sop; e_oeop = in_eop; e_och = bch; e_oda = da; e_odb = in_data;
      end
    end
  endtask

  task automatic compare_all();
    bit rdy_exp;
    rdy_exp = !e_ovld || out_rdy;
    check_eq("a_in_rdy", a_in_rdy, rdy_exp);
    check_eq("b_in_rdy", b_in_rdy, rdy_exp);
    check_eq("a_out_vld", a_out_vld, e_ovld);
    check_eq("b_out_vld", b_out_vld, e_ovld);
    check_eq("a_out_sop", a_out_sop, e_osop);
    check_eq("a_out_eop", a_out_eop, e_oeop);
    check_eq("a_out_ch", a_out_ch, e_och);
    check_eq("a_out_data", a_out_data, e_oda);
    check_eq("b_out_sop", b_out_sop, e_osop);
    check_eq("b_out_eop", b_out_eop, e_oeop);
    check_eq("b_out_ch", b_out_ch, e_och);
    check_eq("b_out_data", b_out_data, e_odb);
    check_eq("a_fb_vld", a_fb_vld, e_fbv);
    check_eq("b_fb_vld", b_fb_vld, e_fbv);
    check_eq("a_fb_ch", a_fb_ch, e_fbch);
    check_eq("b_fb_ch", b_fb_ch, e_fbch);
    check_eq("a_fb_err", a_fb_err, e_fberr);
    check_eq("b_fb_err", b_fb_err, e_fberr);
    check_eq("a_fb_len", a_fb_len, sat(e_fblen, 65535));
    check_eq("b_fb_len", b_fb_len, sat(e_fblen, 3));
    check_eq("a_cnt", a_cnt, ca[cnt_sel]);
    check_eq("b_cnt", b_cnt, cb[cnt_sel]);
    if (a_out_vld === 1'b1 && out_rdy) seen_a.push_back(a_out_data);
  endtask

  // One cycle: drive at the falling edge, check, then model the rising edge.
  task automatic step(input bit v, input bit s, input bit e, input logic [1:0] ch,
                      input logic [7:0] d, input bit ordy, input bit clr, output bit acc);
    in_vld = v; in_sop = s; in_eop = e; in_ch = ch; in_data = d;
    out_rdy = ordy; cnt_clr = clr; cnt_sel = 2'($urandom_range(0, 3));
    #1;
    compare_all();
    acc = v && (!e_ovld || ordy);
    model_clock(acc);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 8'd0, 1, 0, acc);
  endtask

  task automatic send(input bit s, input bit e, input logic [1:0] ch, input logic [7:0] d);
    bit acc;
    acc = 0;
    for (int t = 0; t < 6 && !acc; t++) step(1, s, e, ch, d, 1, 0, acc);
  endtask

  task automatic do_reset();
    in_vld = 0; in_sop = 0; in_eop = 0; cnt_clr = 0; out_rdy = 1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_seen(input string tag, input logic [31:0] exp, input int n);
    logic [31:0] e;
    e = exp;
    check_eq({tag, "_count"}, seen_a.size(), n);
    for (int i = 0; i < n && i < seen_a.size(); i++)
      check_eq(tag, seen_a[i], e[8*(n-1-i) +: 8]);
  endtask

  initial begin
    bit acc;
    rst_n = 1'b0; in_vld = 0; in_sop = 0; in_eop = 0; in_ch = 2'd0; in_data = 8'd0;
    out_rdy = 1; cnt_clr = 0; cnt_sel = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Four-beat delta packet on channel 2
    seen_a.delete();
    send(1, 0, 2'd2, 8'h11); send(0, 0, 2'd0, 8'h22);
    send(0, 0, 2'd0, 8'h33); send(0, 1, 2'd0, 8'h44);
    idle(3);
    check_seen("delta_seq", 32'h11331144, 4);

    // Same packet with a three-cycle downstream stall in the middle
    seen_a.delete();
    send(1, 0, 2'd2, 8'h11); send(0, 0, 2'd0, 8'h22);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 2'd0, 8'h33, 0, 0, acc);
    send(0, 0, 2'd0, 8'h33); send(0, 1, 2'd0, 8'h44);
    idle(3);
    check_seen("stall_seq", 32'h11331144, 4);

    // Orphan beat then single-beat packet
    seen_a.delete();
    send(0, 0, 2'd0, 8'h5A); send(1, 1, 2'd1, 8'h07);
    idle(3);
    check_seen("orphan_seq", 32'h00000007, 1);

    // Unterminated packet closed by a new sop
    send(1, 0, 2'd0, 8'h01); send(0, 0, 2'd0, 8'h02);
    send(1, 0, 2'd3, 8'h03); send(0, 0, 2'd0, 8'h04); send(0, 1, 2'd0, 8'h05);
    idle(3);

    // Reset in the middle of a packet
    send(1, 0, 2'd1, 8'hAA); send(0, 0, 2'd0, 8'hBB);
    do_reset();
    send(0, 1, 2'd0, 8'hCC);
    send(1, 0, 2'd1, 8'h10); send(0, 0, 2'd0, 8'h20); send(0, 1, 2'd0, 8'h30);
    idle(3);

    // Six beats saturate the 2-bit length; clear coincides with the feedback pulse
    send(1, 0, 2'd3, 8'h61);
    for (int i = 0; i < 4; i++) send(0, 0, 2'd0, 8'(8'h62 + i));
    send(0, 1, 2'd0, 8'h66);
    step(0, 0, 0, 2'd0, 8'd0, 1, 1, acc);
    idle(2);

    // Random traffic with stalls, clears and occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
           2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 249) == 0, acc);
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
